// File: rtl/lcd_result_display.sv
// rtl/lcd_result_display.sv - HD44780 16x2 renderer for the mini CPU's last instruction.
// Optional: define LCD_SIGNED_EN to show result as signed with a +/- column.
module lcd_result_display #(
  parameter int POWERUP_CYCLES = 1000000,
  parameter int CMD_CYCLES     = 2000,
  parameter int CLEAR_CYCLES   = 100000,
  parameter int EN_CYCLES      = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        power_on,
  input  logic        update,
  input  logic [3:0]  opcode,
  input  logic [3:0]  dest_addr,
  input  logic [15:0] result,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        busy
);
  localparam int M1   = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
  localparam int M2   = (M1 > CMD_CYCLES) ? M1 : CMD_CYCLES;
  localparam int MAXC = (M2 > 32) ? M2 : 32;
  localparam int CW   = $clog2(MAXC + 1);
`ifdef LCD_SIGNED_EN
  localparam int CONV_LAST = 17;
`else
  localparam int CONV_LAST = 16;
`endif

  typedef enum logic [2:0] {S_OFF, S_PWR_WAIT, S_INIT, S_IDLE, S_CONVERT, S_WRITE} state_t;
  typedef enum logic [1:0] {P_SETUP, P_HIGH, P_WAIT} phase_t;

  state_t        state_q;
  phase_t        phase_q;
  logic [CW-1:0] cnt_q;
  logic [5:0]    idx_q;
  logic          pending_q;
  logic [3:0]    op_q, addr_q;
  logic [15:0]   bin_q;
  logic [19:0]   bcd_q;
  logic [7:0]    data_q;
  logic          rs_q, en_q, on_q, busy_q;
  logic [7:0]    sign_ch;
  logic [CW-1:0] wait_last;

`ifdef LCD_SIGNED_EN
  logic neg_q;
  assign sign_ch = neg_q ? 8'h2D : 8'h2B;
`else
  assign sign_ch = 8'h20;
`endif

  assign wait_last = (!rs_q && data_q == 8'h01) ? CW'(CLEAR_CYCLES - 1) : CW'(CMD_CYCLES - 1);

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: return 8'h38;
      3'd2:       return 8'h0C;
      3'd3:       return 8'h06;
      default:    return 8'h01;
    endcase
  endfunction

  function automatic logic [31:0] mnem(input logic [3:0] op);
    case (op)
      4'd0:    return "LOAD";
      4'd1:    return "ADD ";
      4'd2:    return "ADDI";
      4'd3:    return "SUB ";
      4'd4:    return "SUBI";
      4'd5:    return "MUL ";
      4'd6:    return "CLR ";
      4'd7:    return "DISP";
      default: return "----";
    endcase
  endfunction

  // One shift-add-3 step: adjust every digit >= 5, then shift in the next binary bit.
  function automatic logic [19:0] dabble(input logic [19:0] b_in, input logic in_bit);
    logic [19:0] b;
    b = b_in;
    for (int k = 0; k < 5; k++)
      if (b[4*k +: 4] >= 4'd5) b[4*k +: 4] = b[4*k +: 4] + 4'd3;
    return {b[18:0], in_bit};
  endfunction

  // Byte index 0..33 of a redraw: 0x80, 16 line-1 chars, 0xC0, 16 line-2 chars.
  function automatic logic [8:0] frame_byte(input logic [5:0] i, input logic [3:0] op,
                                            input logic [3:0] addr, input logic [19:0] bcd,
                                            input logic [7:0] sgn);
    logic [31:0] m;
    logic [3:0]  col;
    logic [7:0]  ch;
    m   = mnem(op);
    ch  = 8'h20;
    if (i == 6'd0)  return 9'h080;
    if (i == 6'd17) return 9'h0C0;
    if (i <= 6'd16) begin
      col = 4'(i - 6'd1);
      if (col < 4'd4)        ch = m[8*(3 - int'(col)) +: 8];
      else if (col == 4'd12) ch = 8'h52;
      else if (col == 4'd13) ch = (addr >= 4'd10) ? 8'h31 : 8'h30;
      else if (col == 4'd14) ch = 8'h30 + {4'd0, (addr >= 4'd10) ? addr - 4'd10 : addr};
    end else begin
      col = 4'(i - 6'd18);
      if (col == 4'd10)      ch = sgn;
      else if (col >= 4'd11) ch = 8'h30 + {4'd0, bcd[4*(15 - int'(col)) +: 4]};
    end
    return {1'b1, ch};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_OFF;   phase_q <= P_SETUP; cnt_q <= '0; idx_q <= '0;
      pending_q <= 1'b0;  op_q <= '0; addr_q <= '0; bin_q <= '0; bcd_q <= '0;
      data_q <= '0; rs_q <= 1'b0; en_q <= 1'b0; on_q <= 1'b0; busy_q <= 1'b0;
`ifdef LCD_SIGNED_EN
      neg_q <= 1'b0;
`endif
    end else if (!power_on) begin
      state_q <= S_OFF; phase_q <= P_SETUP; cnt_q <= '0; pending_q <= 1'b0;
      data_q <= '0; rs_q <= 1'b0; en_q <= 1'b0; on_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_q <= S_PWR_WAIT; on_q <= 1'b1; busy_q <= 1'b1; cnt_q <= '0;
        end
        S_PWR_WAIT: begin
          if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
            state_q <= S_INIT; idx_q <= '0; data_q <= 8'h38; rs_q <= 1'b0;
            phase_q <= P_SETUP; cnt_q <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_INIT, S_WRITE: begin
          if (state_q == S_WRITE && update) pending_q <= 1'b1;
          case (phase_q)
            P_SETUP: if (cnt_q == CW'(EN_CYCLES - 1)) begin
                       cnt_q <= '0; phase_q <= P_HIGH; en_q <= 1'b1;
                     end else cnt_q <= cnt_q + 1'b1;
            P_HIGH:  if (cnt_q == CW'(EN_CYCLES - 1)) begin
                       cnt_q <= '0; phase_q <= P_WAIT; en_q <= 1'b0;
                     end else cnt_q <= cnt_q + 1'b1;
            default: if (cnt_q == wait_last) begin
                       cnt_q <= '0; phase_q <= P_SETUP;
                       if (state_q == S_INIT) begin
                         // The final clear blanks the panel, so force a first redraw.
                         if (idx_q == 6'd4) begin
                           state_q <= S_IDLE; busy_q <= 1'b0; pending_q <= 1'b1;
                         end else begin
                           idx_q <= idx_q + 6'd1; data_q <= init_cmd(3'(idx_q + 6'd1));
                         end
                       end else if (idx_q == 6'd33) begin
                         state_q <= S_IDLE; busy_q <= 1'b0;
                       end else begin
                         idx_q <= idx_q + 6'd1;
                         {rs_q, data_q} <= frame_byte(6'(idx_q + 6'd1), op_q, addr_q, bcd_q, sign_ch);
                       end
                     end else cnt_q <= cnt_q + 1'b1;
          endcase
        end
        S_IDLE: begin
          if (update || pending_q) begin
            state_q <= S_CONVERT; busy_q <= 1'b1; pending_q <= 1'b0; cnt_q <= '0;
            op_q <= opcode; addr_q <= dest_addr; bin_q <= result; bcd_q <= '0;
`ifdef LCD_SIGNED_EN
            neg_q <= result[15];
`endif
          end
        end
        S_CONVERT: begin
          if (update) pending_q <= 1'b1;
`ifdef LCD_SIGNED_EN
          if (cnt_q == '0) begin
            if (neg_q) bin_q <= -bin_q;
            cnt_q <= cnt_q + 1'b1;
          end else
`endif
          if (cnt_q == CW'(CONV_LAST)) begin
            state_q <= S_WRITE; idx_q <= '0; data_q <= 8'h80; rs_q <= 1'b0;
            phase_q <= P_SETUP; cnt_q <= '0;
          end else begin
            bcd_q <= dabble(bcd_q, bin_q[15]);
            bin_q <= {bin_q[14:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_OFF;
      endcase
    end
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign lcd_on   = on_q;
  assign busy     = busy_q;
endmodule
